// File: rtl/axi_bridge_mp_pkg.sv
// Shared encodings for the multi-port AXI bridge: request types,
// write-FSM states and the constant AXI attribute fields.
package axi_bridge_mp_pkg;

    localparam logic [2:0] TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_BUSY = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORM  = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

    // A line moves as full 32-bit beats; everything else is a single beat of 2^type[1:0] bytes.
    function automatic logic [2:0] axi_size(input logic [2:0] req_type);
        return (req_type == TYPE_LINE) ? 3'b010 : {1'b0, req_type[1:0]};
    endfunction

endpackage

// File: rtl/axi_rd_arbiter.sv
// Read-port arbiter: N-bit request in, one-hot grant out.
// Macro AXI_BRIDGE_RR_ARB_EN selects round-robin (search starts after the
// last granted port); otherwise fixed priority, lowest index wins.
module axi_rd_arbiter #(
    parameter int N = 2
) (
`ifdef AXI_BRIDGE_RR_ARB_EN
    input  logic         clk,
    input  logic         reset,
`endif
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

`ifdef AXI_BRIDGE_RR_ARB_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last_q;
    logic [PW-1:0] sel;
    logic          found;

    // Two passes: ports above the last winner first, then wrap to the bottom.
    always_comb begin
        gnt   = '0;
        sel   = last_q;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (PW'(j) > last_q)) begin
                gnt[j] = 1'b1;
                sel    = PW'(j);
                found  = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                sel    = PW'(j);
                found  = 1'b1;
            end
        end
    end

    // Remember the winner; reset to the top port so port 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PW'(N - 1);
        end else if (found) begin
            last_q <= sel;
        end
    end
`else
    logic found;

    // Fixed priority: the lowest requesting index takes the grant.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/axi_bridge_mp.sv
// Multi-port cache-to-AXI bridge: N single-outstanding read ports sharing
// the AR/R channels, one line/partial write port on AW/W/B, with reads held
// off while a write to the same line is in flight.
// Macro AXI_BRIDGE_RR_ARB_EN: round-robin read arbitration (default fixed).
//
// state  | meaning
// W_IDLE | no write in flight, wr_rdy high, accepts wr_req
// W_BUSY | AW and/or W beats still outstanding
// W_RESP | waiting for the B response
module axi_bridge_mp
    import axi_bridge_mp_pkg::*;
#(
    parameter int NUM_RD_PORTS = 2,
    parameter int LINE_WORDS   = 4,
    parameter int ID_W         = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ID_W-1:0]              arid,
    output logic [31:0]                  araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic [1:0]                   arlock,
    output logic [3:0]                   arcache,
    output logic [2:0]                   arprot,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [ID_W-1:0]              rid,
    input  logic [31:0]                  rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready,
    output logic [ID_W-1:0]              awid,
    output logic [31:0]                  awaddr,
    output logic [7:0]                   awlen,
    output logic [2:0]                   awsize,
    output logic [1:0]                   awburst,
    output logic [1:0]                   awlock,
    output logic [3:0]                   awcache,
    output logic [2:0]                   awprot,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [ID_W-1:0]              wid,
    output logic [31:0]                  wdata,
    output logic [3:0]                   wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic [ID_W-1:0]              bid,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    output logic                         bready,
    input  logic [NUM_RD_PORTS-1:0]      rd_req,
    input  logic [3*NUM_RD_PORTS-1:0]    rd_type,
    input  logic [32*NUM_RD_PORTS-1:0]   rd_addr,
    output logic [NUM_RD_PORTS-1:0]      rd_rdy,
    output logic [NUM_RD_PORTS-1:0]      ret_valid,
    output logic [NUM_RD_PORTS-1:0]      ret_last,
    output logic [31:0]                  ret_data,
    input  logic                         wr_req,
    input  logic [2:0]                   wr_type,
    input  logic [31:0]                  wr_addr,
    input  logic [3:0]                   wr_wstrb,
    input  logic [32*LINE_WORDS-1:0]     wr_data,
    output logic                         wr_rdy,
    output logic                         wr_done
);

    localparam int              N        = NUM_RD_PORTS;
    localparam int              LINE_LSB = $clog2(4 * LINE_WORDS);
    localparam int              BEAT_W   = $clog2(LINE_WORDS);
    localparam logic [7:0]      LINE_LEN = 8'(LINE_WORDS - 1);
    localparam logic [ID_W-1:0] WR_ID    = ID_W'(NUM_RD_PORTS);

    // read side
    logic [N-1:0]    pend_q, pend_d, eligible, arb_req, gnt, hit;
    logic            ar_valid_q, ar_valid_d;
    logic [ID_W-1:0] ar_id_q, ar_id_d;
    logic [31:0]     ar_addr_q, ar_addr_d;
    logic [7:0]      ar_len_q, ar_len_d;
    logic [2:0]      ar_size_q, ar_size_d;
    logic            r_hs;

    // write side
    wstate_e                 w_state_q, w_state_d;
    logic                    aw_pend_q, aw_pend_d, w_act_q, w_act_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic                    wr_done_q, wr_done_d;
    logic [2:0]              wr_type_q, wr_type_d;
    logic [31:0]             wr_addr_q, wr_addr_d;
    logic [3:0]              wr_wstrb_q, wr_wstrb_d;
    logic [32*LINE_WORDS-1:0] wr_data_q, wr_data_d;
    logic [31:0]             line_word [LINE_WORDS];
    logic                    wr_line, w_last_beat, aw_hs, w_hs;

    axi_rd_arbiter #(.N(N)) u_arb (
`ifdef AXI_BRIDGE_RR_ARB_EN
        .clk   (clk),
        .reset (reset),
`endif
        .req   (arb_req),
        .gnt   (gnt)
    );

    // Eligibility: requesting, nothing outstanding, and not colliding with the write's line.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = rd_req[i] && !pend_q[i] &&
                          !((w_state_q != W_IDLE) &&
                            (rd_addr[32*i+LINE_LSB +: 32-LINE_LSB] == wr_addr_q[31:LINE_LSB]));
        end
        arb_req = (ar_valid_q || reset) ? '0 : eligible;
    end

    assign rd_rdy = gnt;
    assign rready = |pend_q;
    assign r_hs   = rvalid && rready;

    // Route R beats by ID; IDs beyond the read ports match no slice and are dropped.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = r_hs && (rid == ID_W'(i));
        end
        ret_valid = hit;
        ret_last  = rlast ? hit : '0;
    end

    assign ret_data = rdata;

    // AR request latch and per-port pending bits.
    always_comb begin
        pend_d     = pend_q;
        ar_valid_d = ar_valid_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        if (ar_valid_q && arready) begin
            ar_valid_d = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (hit[i] && rlast) begin
                pend_d[i] = 1'b0;
            end
            if (gnt[i]) begin
                pend_d[i]  = 1'b1;
                ar_valid_d = 1'b1;
                ar_id_d    = ID_W'(i);
                ar_addr_d  = rd_addr[32*i +: 32];
                ar_len_d   = (rd_type[3*i +: 3] == TYPE_LINE) ? LINE_LEN : 8'd0;
                ar_size_d  = axi_size(rd_type[3*i +: 3]);
            end
        end
    end

    assign arvalid = ar_valid_q;
    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arlen   = ar_len_q;
    assign arsize  = ar_size_q;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NORM;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;

    // Split the latched line into words so the beat counter selects directly.
    always_comb begin
        for (int b = 0; b < LINE_WORDS; b++) begin
            line_word[b] = wr_data_q[32*b +: 32];
        end
    end

    assign wr_line     = (wr_type_q == TYPE_LINE);
    assign awlen       = wr_line ? LINE_LEN : 8'd0;
    assign w_last_beat = w_act_q && (8'(beat_q) == awlen);
    assign aw_hs       = aw_pend_q && awready;
    assign w_hs        = w_act_q && wready;

    // Write FSM next state: AW and W run independently, B waited for once both finish.
    always_comb begin
        w_state_d  = w_state_q;
        aw_pend_d  = aw_pend_q;
        w_act_d    = w_act_q;
        beat_d     = beat_q;
        wr_done_d  = 1'b0;
        wr_type_d  = wr_type_q;
        wr_addr_d  = wr_addr_q;
        wr_wstrb_d = wr_wstrb_q;
        wr_data_d  = wr_data_q;
        case (w_state_q)
            W_IDLE: begin
                if (wr_req) begin
                    wr_type_d  = wr_type;
                    wr_addr_d  = wr_addr;
                    wr_wstrb_d = wr_wstrb;
                    wr_data_d  = wr_data;
                    aw_pend_d  = 1'b1;
                    w_act_d    = 1'b1;
                    beat_d     = '0;
                    w_state_d  = W_BUSY;
                end
            end
            W_BUSY: begin
                if (aw_hs) begin
                    aw_pend_d = 1'b0;
                end
                if (w_hs) begin
                    if (w_last_beat) begin
                        w_act_d = 1'b0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                if ((!aw_pend_q || aw_hs) && (!w_act_q || (w_hs && w_last_beat))) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    wr_done_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign awvalid = aw_pend_q;
    assign awid    = WR_ID;
    assign awaddr  = wr_addr_q;
    assign awsize  = axi_size(wr_type_q);
    assign awburst = AXI_BURST_INCR;
    assign awlock  = AXI_LOCK_NORM;
    assign awcache = AXI_CACHE_NONE;
    assign awprot  = AXI_PROT_NONE;
    assign wvalid  = w_act_q;
    assign wid     = WR_ID;
    assign wdata   = line_word[beat_q];
    assign wstrb   = wr_line ? 4'hF : wr_wstrb_q;
    assign wlast   = w_last_beat;
    assign bready  = (w_state_q == W_RESP);
    assign wr_rdy  = (w_state_q == W_IDLE);
    assign wr_done = wr_done_q;

    // State register for both channels; reset abandons anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= '0;
            ar_valid_q <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            w_state_q  <= W_IDLE;
            aw_pend_q  <= 1'b0;
            w_act_q    <= 1'b0;
            beat_q     <= '0;
            wr_done_q  <= 1'b0;
            wr_type_q  <= '0;
            wr_addr_q  <= '0;
            wr_wstrb_q <= '0;
            wr_data_q  <= '0;
        end else begin
            pend_q     <= pend_d;
            ar_valid_q <= ar_valid_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            w_state_q  <= w_state_d;
            aw_pend_q  <= aw_pend_d;
            w_act_q    <= w_act_d;
            beat_q     <= beat_d;
            wr_done_q  <= wr_done_d;
            wr_type_q  <= wr_type_d;
            wr_addr_q  <= wr_addr_d;
            wr_wstrb_q <= wr_wstrb_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_axi_bridge_mp.sv
// Directed bench for axi_bridge_mp (default parameters).
module tb_axi_bridge_mp;

    localparam int N   = 2;
    localparam int LW  = 4;
    localparam int IDW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [IDW-1:0]    arid, awid, wid, rid, bid;
    logic [31:0]       araddr, awaddr, wdata, rdata, ret_data, wr_addr;
    logic [7:0]        arlen, awlen;
    logic [2:0]        arsize, awsize, arprot, awprot, wr_type;
    logic [1:0]        arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]        arcache, awcache, wstrb, wr_wstrb;
    logic              arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic              wlast, wvalid, wready, bvalid, bready, wr_req, wr_rdy, wr_done;
    logic [N-1:0]      rd_req, rd_rdy, ret_valid, ret_last;
    logic [3*N-1:0]    rd_type;
    logic [32*N-1:0]   rd_addr;
    logic [32*LW-1:0]  wr_data;

    int n_vec = 0;
    int n_err = 0;

    axi_bridge_mp #(.NUM_RD_PORTS(N), .LINE_WORDS(LW), .ID_W(IDW)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        bid = '0; bresp = '0; bvalid = 1'b0;
        rd_req = '0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        n_vec++; if ({arvalid, awvalid, wvalid, wlast, rready, bready, wr_done, wr_rdy} !== 8'b0000_0001) begin
            n_err++; $display("FAIL reset_flags got %b want 00000001", {arvalid, awvalid, wvalid, wlast, rready, bready, wr_done, wr_rdy}); end
        n_vec++; if ({rd_rdy, ret_valid, ret_last} !== 6'b0) begin
            n_err++; $display("FAIL reset_ports got %b want 000000", {rd_rdy, ret_valid, ret_last}); end
        n_vec++; if ({arburst, arlock, arcache, arprot} !== 11'b01_00_0000_000) begin
            n_err++; $display("FAIL ar_const got %b want 01000000000", {arburst, arlock, arcache, arprot}); end
    endtask

    task automatic test_line_read();
        step();
        arready = 1'b1;
        rd_req  = 2'b10;
        rd_type = {3'b100, 3'b000};
        rd_addr = {32'h1C00_0040, 32'h0};
        #1;
        n_vec++; if (rd_rdy !== 2'b10) begin n_err++; $display("FAIL lr_grant got %b want 10", rd_rdy); end
        step();
        rd_req = '0;
        #1;
        n_vec++; if ({arvalid, arid, arlen, arsize} !== {1'b1, 4'd1, 8'd3, 3'd2}) begin
            n_err++; $display("FAIL lr_ar got v%b id%0d len%0d size%0d want v1 id1 len3 size2", arvalid, arid, arlen, arsize); end
        n_vec++; if (araddr !== 32'h1C00_0040) begin n_err++; $display("FAIL lr_araddr got %h want 1c000040", araddr); end
        for (int k = 0; k < 4; k++) begin
            step();
            rvalid = 1'b1; rid = 4'd1; rdata = 32'hA000_0000 + k; rlast = (k == 3);
            #1;
            n_vec++; if ({ret_valid, ret_last} !== {2'b10, (k == 3) ? 2'b10 : 2'b00}) begin
                n_err++; $display("FAIL lr_beat%0d got v%b l%b want v10 l%b", k, ret_valid, ret_last, (k == 3) ? 2'b10 : 2'b00); end
            n_vec++; if (ret_data !== 32'hA000_0000 + k) begin
                n_err++; $display("FAIL lr_data%0d got %h want %h", k, ret_data, 32'hA000_0000 + k); end
        end
        step();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        n_vec++; if ({rready, arvalid} !== 2'b00) begin n_err++; $display("FAIL lr_done got rready%b arvalid%b want 0 0", rready, arvalid); end
    endtask

    task automatic test_arb();
        logic [1:0] exp_g [4];
`ifdef AXI_BRIDGE_RR_ARB_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        for (int r = 0; r < 4; r++) begin
            step();
            arready = 1'b1;
            rd_req  = 2'b11;
            rd_type = {3'b010, 3'b010};
            rd_addr = {32'h1C00_0300, 32'h1C00_0400};
            #1;
            n_vec++; if (rd_rdy !== exp_g[r]) begin n_err++; $display("FAIL arb_round%0d got %b want %b", r, rd_rdy, exp_g[r]); end
            step();
            rd_req = '0;
            #1;
            n_vec++; if (arid !== ((exp_g[r] == 2'b10) ? 4'd1 : 4'd0)) begin
                n_err++; $display("FAIL arb_arid%0d got %0d want %0d", r, arid, (exp_g[r] == 2'b10) ? 1 : 0); end
            step();
            rvalid = 1'b1; rlast = 1'b1; rid = (exp_g[r] == 2'b10) ? 4'd1 : 4'd0;
            step();
            rvalid = 1'b0; rlast = 1'b0;
        end
    endtask

    task automatic test_line_write();
        logic [31:0] w [4];
        w = '{32'hDDDD_0000, 32'hDDDD_1111, 32'hDDDD_2222, 32'hDDDD_3333};
        step();
        arready = 1'b1; awready = 1'b0; wready = 1'b1;
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h1C00_0080; wr_wstrb = 4'h0;
        wr_data = {w[3], w[2], w[1], w[0]};
        #1;
        n_vec++; if (wr_rdy !== 1'b1) begin n_err++; $display("FAIL lw_rdy got %b want 1", wr_rdy); end
        step();
        wr_req = 1'b0;
        rd_req = 2'b01; rd_type = {3'b000, 3'b010}; rd_addr = {32'h0, 32'h1C00_0084};
        #1;
        n_vec++; if ({awid, awaddr, awlen, awsize} !== {4'd2, 32'h1C00_0080, 8'd3, 3'd2}) begin
            n_err++; $display("FAIL lw_aw got id%0d addr%h len%0d size%0d want id2 addr1c000080 len3 size2", awid, awaddr, awlen, awsize); end
        for (int b = 0; b < 4; b++) begin
            if (b > 0) step();
            awready = (b == 3);
            #1;
            n_vec++; if ({awvalid, wvalid, wlast, wstrb} !== {1'b1, 1'b1, (b == 3), 4'hF}) begin
                n_err++; $display("FAIL lw_beat%0d got aw%b w%b last%b strb%h want aw1 w1 last%b strbF", b, awvalid, wvalid, wlast, wstrb, (b == 3)); end
            n_vec++; if (wdata !== w[b]) begin n_err++; $display("FAIL lw_wdata%0d got %h want %h", b, wdata, w[b]); end
            n_vec++; if ({rd_rdy, arvalid} !== 3'b000) begin
                n_err++; $display("FAIL lw_raw%0d got rdy%b arvalid%b want 00 0", b, rd_rdy, arvalid); end
        end
        step();
        awready = 1'b0;
        #1;
        n_vec++; if ({bready, awvalid, wvalid, rd_rdy} !== 5'b10000) begin
            n_err++; $display("FAIL lw_resp got b%b aw%b w%b rdy%b want 1 0 0 00", bready, awvalid, wvalid, rd_rdy); end
        step();
        bvalid = 1'b1;
        #1;
        n_vec++; if ({bready, wr_done, rd_rdy} !== 4'b1000) begin
            n_err++; $display("FAIL lw_bvalid got b%b done%b rdy%b want 1 0 00", bready, wr_done, rd_rdy); end
        step();
        bvalid = 1'b0;
        #1;
        n_vec++; if ({wr_done, wr_rdy, rd_rdy, arvalid} !== 5'b11010) begin
            n_err++; $display("FAIL lw_done got done%b rdy%b rd_rdy%b arvalid%b want 1 1 01 0", wr_done, wr_rdy, rd_rdy, arvalid); end
        step();
        rd_req = '0;
        #1;
        n_vec++; if ({wr_done, arvalid, arid, arlen, arsize} !== {1'b0, 1'b1, 4'd0, 8'd0, 3'd2}) begin
            n_err++; $display("FAIL lw_read_ar got done%b v%b id%0d len%0d size%0d want 0 1 0 0 2", wr_done, arvalid, arid, arlen, arsize); end
        n_vec++; if (araddr !== 32'h1C00_0084) begin n_err++; $display("FAIL lw_read_addr got %h want 1c000084", araddr); end
        step();
        rvalid = 1'b1; rid = 4'd0; rlast = 1'b1; rdata = 32'h5555_AAAA;
        #1;
        n_vec++; if ({ret_valid, ret_last} !== 4'b0101) begin
            n_err++; $display("FAIL lw_read_ret got v%b l%b want 01 01", ret_valid, ret_last); end
        step();
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_byte_write();
        step();
        awready = 1'b1; wready = 1'b1;
        wr_req = 1'b1; wr_type = 3'b000; wr_addr = 32'h1C00_0102; wr_wstrb = 4'b0100;
        wr_data = '0; wr_data[31:0] = 32'h1122_3344;
        step();
        wr_req = 1'b0;
        #1;
        n_vec++; if ({awvalid, awlen, awsize} !== {1'b1, 8'd0, 3'd0}) begin
            n_err++; $display("FAIL bw_aw got v%b len%0d size%0d want 1 0 0", awvalid, awlen, awsize); end
        n_vec++; if ({wvalid, wlast, wstrb, wdata} !== {1'b1, 1'b1, 4'b0100, 32'h1122_3344}) begin
            n_err++; $display("FAIL bw_w got v%b last%b strb%b data%h want 1 1 0100 11223344", wvalid, wlast, wstrb, wdata); end
        step();
        bvalid = 1'b1;
        #1;
        n_vec++; if ({bready, awvalid, wvalid} !== 3'b100) begin
            n_err++; $display("FAIL bw_resp got b%b aw%b w%b want 1 0 0", bready, awvalid, wvalid); end
        step();
        bvalid = 1'b0;
        #1;
        n_vec++; if ({wr_done, wr_rdy} !== 2'b11) begin n_err++; $display("FAIL bw_done got done%b rdy%b want 1 1", wr_done, wr_rdy); end
        step();
        #1;
        n_vec++; if (wr_done !== 1'b0) begin n_err++; $display("FAIL bw_done_pulse got %b want 0", wr_done); end
    endtask

    task automatic test_reset_mid();
        step();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h1C00_0500; wr_data = {4{32'hBEEF_0000}};
        rd_req = 2'b10; rd_type = {3'b100, 3'b000}; rd_addr = {32'h1C00_0600, 32'h0};
        step();
        wr_req = 1'b0; rd_req = '0; wready = 1'b1;
        #1;
        n_vec++; if ({awvalid, arvalid, rready} !== 3'b111) begin
            n_err++; $display("FAIL rm_busy got aw%b ar%b rr%b want 1 1 1", awvalid, arvalid, rready); end
        step();
        wready = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_vec++; if ({arvalid, awvalid, wvalid, wlast, rready, bready, wr_done, wr_rdy} !== 8'b0000_0001) begin
            n_err++; $display("FAIL rm_flags got %b want 00000001", {arvalid, awvalid, wvalid, wlast, rready, bready, wr_done, wr_rdy}); end
        n_vec++; if ({rd_rdy, ret_valid, ret_last} !== 6'b0) begin
            n_err++; $display("FAIL rm_ports got %b want 000000", {rd_rdy, ret_valid, ret_last}); end
        step();
        arready = 1'b1;
        rd_req = 2'b01; rd_type = {3'b000, 3'b100}; rd_addr = {32'h0, 32'h1C00_0200};
        #1;
        n_vec++; if (rd_rdy !== 2'b01) begin n_err++; $display("FAIL rm_grant got %b want 01", rd_rdy); end
        step();
        rd_req = '0;
        #1;
        n_vec++; if ({arvalid, arid, arlen, araddr} !== {1'b1, 4'd0, 8'd3, 32'h1C00_0200}) begin
            n_err++; $display("FAIL rm_ar got v%b id%0d len%0d addr%h want 1 0 3 1c000200", arvalid, arid, arlen, araddr); end
        for (int k = 0; k < 4; k++) begin
            step();
            rvalid = 1'b1; rid = 4'd0; rdata = 32'hC000_0000 + k; rlast = (k == 3);
            #1;
            n_vec++; if ({ret_valid, ret_last, ret_data} !== {2'b01, (k == 3) ? 2'b01 : 2'b00, 32'hC000_0000 + k}) begin
                n_err++; $display("FAIL rm_beat%0d got v%b l%b d%h", k, ret_valid, ret_last, ret_data); end
        end
        step();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        n_vec++; if (rready !== 1'b0) begin n_err++; $display("FAIL rm_idle got rready%b want 0", rready); end
    endtask

    // Stray-beat drop: an ID past the read ports is accepted but routed nowhere.
    task automatic test_drop_beat();
        step();
        arready = 1'b1;
        rd_req = 2'b01; rd_type = {3'b000, 3'b010}; rd_addr = {32'h0, 32'h1C00_0700};
        step();
        rd_req = '0;
        step();
        rvalid = 1'b1; rid = 4'd3; rlast = 1'b1;
        #1;
        n_vec++; if ({rready, ret_valid, ret_last} !== 5'b10000) begin
            n_err++; $display("FAIL drop_beat got rr%b v%b l%b want 1 00 00", rready, ret_valid, ret_last); end
        step();
        rid = 4'd0;
        #1;
        n_vec++; if ({rready, ret_valid, ret_last} !== 5'b10101) begin
            n_err++; $display("FAIL drop_then_real got rr%b v%b l%b want 1 01 01", rready, ret_valid, ret_last); end
        step();
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_line_read();
        test_arb();
        test_line_write();
        test_byte_write();
        test_reset_mid();
        test_drop_beat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before bench completed");
        $fatal(1, "watchdog");
    end

endmodule
